// File: rtl/sws_debouncer_pkg.sv
// ----------------------------------------------------------------------------
// sws_debouncer_pkg
// Shared constants for the switch-bus debouncer slice.
//   NUM_SW_DEFAULT          : number of switch lines on the board bus
//   DEBOUNCE_CYCLES_DEFAULT : stable cycles needed to accept a level (10 ms @ 125 MHz)
//   SYNC_STAGES             : depth of the per-bit input synchroniser
//   ready_cnt_width()       : width of the startup counter that drives ready_o
// ----------------------------------------------------------------------------
package sws_debouncer_pkg;

    localparam int NUM_SW_DEFAULT          = 2;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 1250000;
    localparam int SYNC_STAGES             = 2;

    // The startup counter must be able to hold DEBOUNCE_CYCLES+1.
    function automatic int ready_cnt_width(input int debounce_cycles);
        return $clog2(debounce_cycles + 2);
    endfunction

endpackage

// File: rtl/sws_debouncer_if.sv
// ----------------------------------------------------------------------------
// sws_debouncer_if
// Bundles the raw switch bus and the conditioned outputs of the debouncer.
//   sws_2bits_tri_i : raw asynchronous switch levels (into the debouncer)
//   sws_stable_o    : debounced levels
//   sws_rise_o      : one-cycle pulse on a 0->1 of a stable bit
//   sws_fall_o      : one-cycle pulse on a 1->0 of a stable bit
//   sws_change_o    : OR of all rise/fall bits
//   ready_o         : sticky, high once the first debounce window has elapsed
// Modports: master = board/consumer side, slave = debouncer side.
// ----------------------------------------------------------------------------
interface sws_debouncer_if
    import sws_debouncer_pkg::*;
#(
    parameter int NUM_SW = NUM_SW_DEFAULT
);

    logic [NUM_SW-1:0] sws_2bits_tri_i;
    logic [NUM_SW-1:0] sws_stable_o;
    logic [NUM_SW-1:0] sws_rise_o;
    logic [NUM_SW-1:0] sws_fall_o;
    logic              sws_change_o;
    logic              ready_o;

    modport master (
        output sws_2bits_tri_i,
        input  sws_stable_o,
        input  sws_rise_o,
        input  sws_fall_o,
        input  sws_change_o,
        input  ready_o
    );

    modport slave (
        input  sws_2bits_tri_i,
        output sws_stable_o,
        output sws_rise_o,
        output sws_fall_o,
        output sws_change_o,
        output ready_o
    );

endinterface

// File: rtl/sws_debouncer_cell.sv
// ----------------------------------------------------------------------------
// debounce_cell
// One switch line: SYNC_STAGES-deep synchroniser, window counter, accepted
// (stable) level and registered rise/fall strobes.
//   clk, rst : system clock, synchronous active-high reset
//   raw      : asynchronous switch level
//   stable   : debounced level
//   rise     : one-cycle pulse, same cycle as stable going 0->1
//   fall     : one-cycle pulse, same cycle as stable going 1->0
// ----------------------------------------------------------------------------
module debounce_cell
    import sws_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable,
    output logic rise,
    output logic fall
);

    localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sync_s;
    logic [CNT_W-1:0]       cnt_r;
    logic [CNT_W-1:0]       cnt_nxt_s;
    logic                   stable_r;
    logic                   stable_nxt_s;
    logic                   rise_r;
    logic                   rise_nxt_s;
    logic                   fall_r;
    logic                   fall_nxt_s;

    // Shift the raw level through the synchroniser; only the last stage is used.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], raw};
        end
    end

    assign sync_s = sync_r[SYNC_STAGES-1];

    // Window counting: any sample equal to the accepted level restarts the
    // window; the DEBOUNCE_CYCLES-th differing sample in a row is accepted.
    always_comb begin
        cnt_nxt_s    = cnt_r;
        stable_nxt_s = stable_r;
        rise_nxt_s   = 1'b0;
        fall_nxt_s   = 1'b0;
        if (sync_s == stable_r) begin
            cnt_nxt_s = '0;
        end else if (cnt_r == CNT_LAST) begin
            cnt_nxt_s    = '0;
            stable_nxt_s = sync_s;
            rise_nxt_s   = sync_s;
            fall_nxt_s   = ~sync_s;
        end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
        end
    end

    // Counter, accepted level and strobes; strobes land with the new level.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r    <= '0;
            stable_r <= 1'b0;
            rise_r   <= 1'b0;
            fall_r   <= 1'b0;
        end else begin
            cnt_r    <= cnt_nxt_s;
            stable_r <= stable_nxt_s;
            rise_r   <= rise_nxt_s;
            fall_r   <= fall_nxt_s;
        end
    end

    assign stable = stable_r;
    assign rise   = rise_r;
    assign fall   = fall_r;

endmodule

// File: rtl/sws_debouncer.sv
// ----------------------------------------------------------------------------
// sws_debouncer
// Input-side conditioning of the board switch bus: per-bit synchronise and
// debounce, plus a combined change strobe and a sticky startup-ready flag.
//   clk : system clock (single domain)
//   rst : synchronous active-high reset
//   sw  : sws_debouncer_if.slave (raw switches in, stable/rise/fall/change/ready out)
// ----------------------------------------------------------------------------
module sws_debouncer
    import sws_debouncer_pkg::*;
#(
    parameter int NUM_SW          = NUM_SW_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    sws_debouncer_if.slave  sw
);

    // ready_o rises on the same edge a switch held at 1 through reset is
    // accepted: DEBOUNCE_CYCLES+2 edges after the last reset edge.
    localparam int             RDY_W    = ready_cnt_width(DEBOUNCE_CYCLES);
    localparam logic [RDY_W-1:0] RDY_LAST = RDY_W'(DEBOUNCE_CYCLES + 1);

    logic [NUM_SW-1:0] stable_s;
    logic [NUM_SW-1:0] rise_s;
    logic [NUM_SW-1:0] fall_s;
    logic [RDY_W-1:0]  rdy_cnt_r;
    logic [RDY_W-1:0]  rdy_cnt_nxt_s;
    logic              ready_r;
    logic              ready_nxt_s;

    for (genvar i = 0; i < NUM_SW; i++) begin : g_cell
        debounce_cell #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_cell (
            .clk    (clk),
            .rst    (rst),
            .raw    (sw.sws_2bits_tri_i[i]),
            .stable (stable_s[i]),
            .rise   (rise_s[i]),
            .fall   (fall_s[i])
        );
    end

    // Startup counter: runs once after reset, then parks with ready held high.
    always_comb begin
        rdy_cnt_nxt_s = rdy_cnt_r;
        ready_nxt_s   = ready_r;
        if (ready_r) begin
            rdy_cnt_nxt_s = rdy_cnt_r;
        end else if (rdy_cnt_r == RDY_LAST) begin
            ready_nxt_s = 1'b1;
        end else begin
            rdy_cnt_nxt_s = rdy_cnt_r + RDY_W'(1);
        end
    end

    // Startup counter and ready flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdy_cnt_r <= '0;
            ready_r   <= 1'b0;
        end else begin
            rdy_cnt_r <= rdy_cnt_nxt_s;
            ready_r   <= ready_nxt_s;
        end
    end

    assign sw.sws_stable_o = stable_s;
    assign sw.sws_rise_o   = rise_s;
    assign sw.sws_fall_o   = fall_s;
    // Both inputs are registered, so the OR cannot stretch or split a pulse.
    assign sw.sws_change_o = |(rise_s | fall_s);
    assign sw.ready_o      = ready_r;

endmodule
